// File: rtl/wb_ram512x32_ctrl.sv
// wb_ram512x32_ctrl
// Wishbone B4 classic slave in front of a 32-bit byte-writable synchronous
// SRAM macro. Writes complete in one cycle (ack in the 2nd cycle). Reads wait
// out the SRAM's one-cycle read latency, register the data, and ack in the
// 3rd cycle.
//
// Optional build macro: RAMCTRL_CLEAR_EN
//   When defined, every reset is followed by a clear pass that writes zero to
//   all 2**ADR_W words. busy_o stays high and bus requests are held off until
//   the pass completes.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i  bus cycle / strobe
//   wb_we_i, wb_sel_i   write enable, byte lanes
//   wb_adr_i, wb_dat_i  byte address, write data
//   wb_dat_o, wb_ack_o  registered read data, one-cycle acknowledge
//   ram_wen_o, ram_sel_o, ram_adr_o, ram_dat_o  SRAM write/address/data drive
//   ram_dat_i           SRAM read data (valid one cycle after the address edge)
//   busy_o              high whenever a new request cannot be accepted
module wb_ram512x32_ctrl #(
  parameter int ADR_W   = 7,
  parameter int ADR_LSB = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             ram_wen_o,
  output logic [3:0]       ram_sel_o,
  output logic [ADR_W-1:0] ram_adr_o,
  output logic [31:0]      ram_dat_o,
  input  logic [31:0]      ram_dat_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    ACK  = 2'd2
`ifdef RAMCTRL_CLEAR_EN
    ,
    CLR  = 2'd3
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [ADR_W-1:0] adr_q;
  logic             req;
  logic [ADR_W-1:0] bus_adr;

  assign req     = wb_cyc_i & wb_stb_i;
  // Address bits above the word index are dropped, so the space aliases.
  assign bus_adr = wb_adr_i[ADR_LSB+ADR_W-1:ADR_LSB];

  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb_adr_i[31:ADR_LSB+ADR_W], wb_adr_i[ADR_LSB-1:0]};

`ifdef RAMCTRL_CLEAR_EN
  localparam logic [ADR_W-1:0] CNT_LAST = {ADR_W{1'b1}};
  localparam logic [ADR_W-1:0] CNT_ONE  = {{(ADR_W-1){1'b0}}, 1'b1};
  logic [ADR_W-1:0] cnt;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
`ifdef RAMCTRL_CLEAR_EN
      state <= CLR;
      cnt   <= '0;
`else
      state <= IDLE;
`endif
      adr_q    <= '0;
      wb_dat_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req)
        adr_q <= bus_adr;
      // Read data is captured even when the master aborts in RD.
      if (state == RD)
        wb_dat_o <= ram_dat_i;
`ifdef RAMCTRL_CLEAR_EN
      if (state == CLR)
        cnt <= cnt + CNT_ONE;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    wb_ack_o  = 1'b0;
    ram_wen_o = 1'b0;
    ram_sel_o = 4'h0;
    ram_adr_o = adr_q;
    ram_dat_o = wb_dat_i;
    case (state)
      IDLE: begin
        // In IDLE the SRAM sees the bus directly so a write lands on the
        // accepting edge and a read address is launched without delay.
        ram_adr_o = bus_adr;
        ram_sel_o = req ? wb_sel_i : 4'h0;
        ram_wen_o = req & wb_we_i;
        if (req)
          state_nxt = wb_we_i ? ACK : RD;
      end
      RD: begin
        state_nxt = wb_cyc_i ? ACK : IDLE;
      end
      ACK: begin
        wb_ack_o  = 1'b1;
        state_nxt = IDLE;
      end
`ifdef RAMCTRL_CLEAR_EN
      CLR: begin
        ram_wen_o = 1'b1;
        ram_sel_o = 4'hF;
        ram_adr_o = cnt;
        ram_dat_o = '0;
        if (cnt == CNT_LAST)
          state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    // The IDLE pass-through paths are combinational, so hold them at zero
    // while reset is asserted.
    if (rst_i) begin
      wb_ack_o  = 1'b0;
      ram_wen_o = 1'b0;
      ram_sel_o = 4'h0;
      ram_adr_o = '0;
      ram_dat_o = '0;
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_wb_ram512x32_ctrl.sv
// Testbench for wb_ram512x32_ctrl: directed cases plus randomized Wishbone
// traffic against a word-array reference model and a behavioural SRAM.
module tb_wb_ram512x32_ctrl;
  localparam int ADR_W = 7;
  localparam int DEPTH = 1 << ADR_W;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]       wb_sel_i;
  logic [31:0]      wb_adr_i, wb_dat_i, wb_dat_o;
  logic             wb_ack_o, ram_wen_o, busy_o;
  logic [3:0]       ram_sel_o;
  logic [ADR_W-1:0] ram_adr_o;
  logic [31:0]      ram_dat_o, ram_dat_i;

  logic [31:0] sram    [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rd;
  int errors = 0;
  int checks = 0;

  wb_ram512x32_ctrl #(.ADR_W(ADR_W), .ADR_LSB(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .ram_wen_o(ram_wen_o), .ram_sel_o(ram_sel_o), .ram_adr_o(ram_adr_o),
    .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural synchronous SRAM: byte writes, one-cycle read latency.
  always @(posedge clk_i) begin
    if (ram_wen_o)
      for (int b = 0; b < 4; b++)
        if (ram_sel_o[b]) sram[ram_adr_o][8*b +: 8] <= ram_dat_o[8*b +: 8];
    ram_dat_i <= sram[ram_adr_o];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] adr);
    return int'((adr / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  task automatic bus_idle();
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    wb_sel_i = 0; wb_adr_i = 0; wb_dat_i = 0;
  endtask

  // After reset release: wait out the clear pass when it is built in.
  task automatic wait_ready();
`ifdef RAMCTRL_CLEAR_EN
    int n;
    n = 0;
    while (busy_o && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    chk("clr_len", n, 128);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
`endif
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int w;
    w = widx(adr);
    @(negedge clk_i);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1;
    wb_sel_i = sel; wb_adr_i = adr; wb_dat_i = dat;
    #1;
    chk("wr_wen", ram_wen_o, 1);
    chk("wr_sel", ram_sel_o, sel);
    chk("wr_adr", ram_adr_o, w);
    chk("wr_dat", ram_dat_o, dat);
    chk("wr_ack_early", wb_ack_o, 0);
    ref_mem[w] = merge(ref_mem[w], dat, sel);
    @(negedge clk_i);
    chk("wr_ack", wb_ack_o, 1);
    chk("wr_wen_in_ack", ram_wen_o, 0);
    chk("wr_dato_hold", wb_dat_o, last_rd);
    bus_idle();
    @(negedge clk_i);
    chk("wr_ack_end", wb_ack_o, 0);
    chk("wr_busy_end", busy_o, 0);
  endtask

  task automatic do_read(input logic [31:0] adr);
    int w;
    w = widx(adr);
    @(negedge clk_i);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0;
    wb_sel_i = 4'($urandom); wb_adr_i = adr; wb_dat_i = $urandom;
    #1;
    chk("rd_wen", ram_wen_o, 0);
    chk("rd_adr", ram_adr_o, w);
    @(negedge clk_i);
    chk("rd_ack_early", wb_ack_o, 0);
    chk("rd_busy", busy_o, 1);
    chk("rd_wen_in_rd", ram_wen_o, 0);
    @(negedge clk_i);
    chk("rd_ack", wb_ack_o, 1);
    chk("rd_data", wb_dat_o, ref_mem[w]);
    last_rd = ref_mem[w];
    bus_idle();
    @(negedge clk_i);
    chk("rd_ack_end", wb_ack_o, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] adr;
    int op;
`ifdef RAMCTRL_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) sram[i] = 32'hA5A5_5A5A;
`else
    for (int i = 0; i < DEPTH; i++) sram[i] = 32'h0;
`endif
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    last_rd = 32'h0;

    // Reset with a write request on the bus: everything must read zero.
    rst_i = 1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1;
    wb_sel_i = 4'hF; wb_adr_i = 32'h0000_01FC; wb_dat_i = 32'hFFFF_FFFF;
    #1;
    chk("rst_ack", wb_ack_o, 0);
    chk("rst_wen", ram_wen_o, 0);
    chk("rst_sel", ram_sel_o, 0);
    chk("rst_adr", ram_adr_o, 0);
    chk("rst_rdat", ram_dat_o, 0);
    chk("rst_dato", wb_dat_o, 0);
    bus_idle();
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    wait_ready();
    chk("idle_busy", busy_o, 0);

    // Full-word write then read back.
    do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    do_read(32'h0000_0010);
    chk("t1_const", wb_dat_o, 32'hDEAD_BEEF);

    // Byte-lane write over an existing word.
    do_write(32'h0000_0020, 32'h1122_3344, 4'hF);
    do_write(32'h0000_0020, 32'h0000_00AA, 4'b0001);
    do_read(32'h0000_0020);
    chk("t2_const", wb_dat_o, 32'h1122_33AA);

    // Aliasing through the dropped upper address bits.
    do_write(32'h0000_0204, 32'h1234_5678, 4'hF);
    do_read(32'h0000_0004);
    chk("t3_const", wb_dat_o, 32'h1234_5678);

    // Zero byte-select write: acked, memory unchanged.
    do_write(32'h0000_0020, 32'hFFFF_FFFF, 4'h0);
    do_read(32'h0000_0020);
    chk("t4_const", wb_dat_o, 32'h1122_33AA);

    // Read abort: cyc dropped in RD.
    do_write(32'h0000_0008, 32'hCAFE_F00D, 4'hF);
    @(negedge clk_i);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_sel_i = 4'hF; wb_adr_i = 32'h8;
    @(negedge clk_i);
    bus_idle();
    @(negedge clk_i);
    chk("abort_ack", wb_ack_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_dato", wb_dat_o, 32'hCAFE_F00D);
    last_rd = 32'hCAFE_F00D;
    do_write(32'h0000_000C, 32'h0BAD_F00D, 4'hF);

    // Asynchronous reset while in RD.
    @(negedge clk_i);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_sel_i = 4'hF; wb_adr_i = 32'h10;
    @(negedge clk_i);
    rst_i = 1;
    #1;
    chk("arst_ack", wb_ack_o, 0);
    chk("arst_wen", ram_wen_o, 0);
    chk("arst_dato", wb_dat_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_adr", ram_adr_o, 0);
    bus_idle();
    @(negedge clk_i);
    rst_i = 0;
    last_rd = 32'h0;
    wait_ready();
    do_read(32'h0000_0010);
    do_write(32'h0000_0030, 32'h5555_AAAA, 4'hF);
    do_read(32'h0000_0030);

    // Randomized traffic, with addresses focused on a small set of words.
    for (int i = 0; i < 300; i++) begin
      op  = $urandom_range(0, 4);
      adr = ($urandom & 32'hFFFF_FE00) | (32'($urandom_range(0, 15)) << 2)
            | 32'($urandom_range(0, 3));
      if (op <= 1) begin
        do_write(adr, $urandom, 4'($urandom));
      end else if (op <= 3) begin
        do_read(adr);
      end else begin
        // Half-asserted bus: must not start a transfer.
        @(negedge clk_i);
        wb_cyc_i = 1'($urandom);
        wb_stb_i = ~wb_cyc_i;
        wb_we_i  = 1'($urandom);
        wb_sel_i = 4'($urandom); wb_adr_i = adr; wb_dat_i = $urandom;
        #1;
        chk("noreq_wen", ram_wen_o, 0);
        chk("noreq_sel", ram_sel_o, 0);
        @(negedge clk_i);
        chk("noreq_ack", wb_ack_o, 0);
        chk("noreq_busy", busy_o, 0);
        chk("noreq_dato", wb_dat_o, last_rd);
        bus_idle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
